// File: rtl/result_uart_drain_pkg.sv
// Shared encodings and constants for the systolic-array result drain.
package result_uart_drain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        HI   = 2'd2,
        LO   = 2'd3
    } state_t;

    localparam logic [7:0] DEF_HDR_BYTE  = 8'hA5;
    localparam int         BYTES_PER_RES = 2;

endpackage

// File: rtl/result_uart_drain.sv
// Snapshots the 4x4 array results on done and streams them as header + hi/lo bytes.
// First byte valid one cycle after done; tx_data/tx_valid hold while tx_ready is low.
module result_uart_drain
    import result_uart_drain_pkg::*;
#(
    parameter int         NUM_RES  = 16,
    parameter int         RES_W    = 16,
    parameter bit         HDR_EN   = 1'b1,
    parameter logic [7:0] HDR_BYTE = DEF_HDR_BYTE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     done,
    input  logic [NUM_RES*RES_W-1:0] c_flat,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overrun
);

    localparam int RI_W = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;

    state_t                   state;
    logic [RI_W-1:0]          res_idx;
    logic                     byte_sel;
    logic [NUM_RES*RES_W-1:0] shadow;

    logic                     xfer;
    logic                     last_res;
    logic [RI_W-1:0]          mux_idx;
    logic                     mux_lo;
    logic [RI_W+3:0]          mux_base;
    logic [7:0]               mux_byte;

    assign xfer     = tx_valid & tx_ready;
    assign last_res = (res_idx == RI_W'(NUM_RES - 1));

    // Mux picks the byte that follows the one currently on tx_data:
    // after HDR -> C[idx] hi, after hi -> C[idx] lo, after lo -> C[idx+1] hi.
    always_comb begin
        mux_idx  = res_idx + RI_W'(byte_sel);
        mux_lo   = (state != HDR) & ~byte_sel;
        mux_base = {mux_idx, ~mux_lo, 3'b000};
        mux_byte = shadow[mux_base +: 8];
    end

    // Shadow bank needs no reset; it is only read after a capture.
    always_ff @(posedge clk) begin
        if (state == IDLE && done) begin
            shadow <= c_flat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            res_idx    <= '0;
            byte_sel   <= 1'b0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (done && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (done) begin
                        res_idx  <= '0;
                        byte_sel <= 1'b0;
                        busy     <= 1'b1;
                        tx_valid <= 1'b1;
                        if (HDR_EN) begin
                            state   <= HDR;
                            tx_data <= HDR_BYTE;
                        end else begin
                            state   <= HI;
                            tx_data <= c_flat[RES_W-1 -: 8];
                        end
                    end
                end
                HDR: begin
                    if (xfer) begin
                        state   <= HI;
                        tx_data <= mux_byte;
                    end
                end
                HI: begin
                    if (xfer) begin
                        state    <= LO;
                        byte_sel <= 1'b1;
                        tx_data  <= mux_byte;
                    end
                end
                LO: begin
                    if (xfer) begin
                        byte_sel <= 1'b0;
                        if (last_res) begin
                            state      <= IDLE;
                            tx_valid   <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            state   <= HI;
                            res_idx <= res_idx + 1'b1;
                            tx_data <= mux_byte;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_uart_drain.sv
// Scoreboard bench for result_uart_drain: header/no-header frames, stalls, overrun, reset, back-to-back.
module tb_result_uart_drain;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         done = 1'b0;
    logic         done2 = 1'b0;
    logic         tx_ready = 1'b0;
    logic [255:0] c_flat = '0;

    logic [7:0] tx_data, tx_data2;
    logic       tx_valid, busy, frame_done, overrun;
    logic       tx_valid2, busy2, frame_done2, overrun2;

    int n_cmp = 0;
    int n_fail = 0;
    int stall_err = 0;

    logic [7:0] got[$];
    logic [7:0] got2[$];
    logic [7:0] exp_q[$];

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    result_uart_drain dut (
        .clk(clk), .reset(reset), .done(done), .c_flat(c_flat),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    result_uart_drain #(.HDR_EN(1'b0)) dut_nh (
        .clk(clk), .reset(reset), .done(done2), .c_flat(c_flat),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready),
        .busy(busy2), .frame_done(frame_done2), .overrun(overrun2)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so the negedge view predicts the next edge.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(tx_valid && tx_data == prev_data)) stall_err++;
            if (tx_valid && tx_ready) got.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    function automatic logic [255:0] kpat();
        logic [255:0] f;
        for (int k = 0; k < 16; k++) f[16*k +: 16] = 16'h0101 * k;
        return f;
    endfunction

    function automatic logic [255:0] bpat();
        logic [255:0] f;
        for (int k = 0; k < 16; k++) f[16*k +: 16] = (16'h0203 * k) ^ 16'h5A5A;
        return f;
    endfunction

    task automatic push_exp(input logic [255:0] f, input bit hdr);
        if (hdr) exp_q.push_back(8'hA5);
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(f[16*k+8 +: 8]);
            exp_q.push_back(f[16*k +: 8]);
        end
    endtask

    task automatic clear_q();
        got.delete();
        got2.delete();
        exp_q.delete();
    endtask

    task automatic pulse_done();
        @(posedge clk); #1 done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
    endtask

    task automatic wait_fd(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!frame_done && cyc < 500);
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (tx_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        n_cmp++; if (tx_data !== 8'h00)   begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_cmp++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_cmp++; if (overrun !== 1'b0)    begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_basic();
        int cyc;
        clear_q();
        c_flat = kpat();
        push_exp(c_flat, 1'b1);
        tx_ready = 1'b1;
        pulse_done();
        n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            n_fail++; $display("FAIL basic_first: got v=%b d=%h want v=1 d=a5", tx_valid, tx_data);
        end
        wait_fd(cyc);
        n_cmp++; if (cyc !== 33) begin n_fail++; $display("FAIL basic_latency: got %0d edges want 33", cyc); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b want 0", busy); end
        n_cmp++; if (got.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL basic_count: got %0d bytes want %0d", got.size(), exp_q.size());
        end
        while (got.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL basic_byte: got %h want %h", g, e); end
        end
        @(posedge clk); #1;
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL basic_fd_pulse: got %b want 0", frame_done); end
    endtask

    task automatic test_stall();
        int i;
        clear_q();
        stall_err = 0;
        c_flat = kpat();
        push_exp(c_flat, 1'b1);
        tx_ready = 1'b1;
        pulse_done();
        i = 0;
        while (!frame_done && i < 500) begin
            tx_ready = (i % 3 == 0);
            @(posedge clk); #1;
            i++;
        end
        tx_ready = 1'b1;
        n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL stall_timeout: frame_done=%b want 1", frame_done); end
        n_cmp++; if (stall_err !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable stalls want 0", stall_err); end
        n_cmp++; if (got.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL stall_count: got %0d bytes want %0d", got.size(), exp_q.size());
        end
        while (got.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL stall_byte: got %h want %h", g, e); end
        end
    endtask

    task automatic test_overrun();
        int cyc;
        clear_q();
        c_flat = kpat();
        push_exp(c_flat, 1'b1);
        tx_ready = 1'b1;
        pulse_done();
        repeat (5) @(posedge clk);
        #1 c_flat = {16{16'hFFFF}};
        done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b want 1", overrun); end
        wait_fd(cyc);
        n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
        n_cmp++; if (got.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL overrun_count: got %0d bytes want %0d", got.size(), exp_q.size());
        end
        while (got.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL overrun_byte: got %h want %h", g, e); end
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL overrun_no_refire: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        clear_q();
        c_flat = kpat();
        tx_ready = 1'b1;
        pulse_done();
        repeat (9) @(posedge clk);
        #1 tx_ready = 1'b0;
        n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h04) begin
            n_fail++; $display("FAIL rstmid_10th: got v=%b d=%h want v=1 d=04", tx_valid, tx_data);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", tx_valid); end
        n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (overrun !== 1'b0)  begin n_fail++; $display("FAIL rstmid_overrun: got %b want 0", overrun); end
        @(posedge clk); #1 reset = 1'b0;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_resume: got %b want 0", tx_valid); end
        clear_q();
        push_exp(c_flat, 1'b1);
        pulse_done();
        wait_fd(cyc);
        n_cmp++; if (got.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rstmid_count: got %0d bytes want %0d", got.size(), exp_q.size());
        end
        if (got.size() > 0) begin
            n_cmp++; if (got[0] !== 8'hA5) begin n_fail++; $display("FAIL rstmid_hdr: got %h want a5", got[0]); end
        end
        while (got.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL rstmid_byte: got %h want %h", g, e); end
        end
    endtask

    task automatic test_no_hdr();
        int cyc;
        clear_q();
        c_flat = kpat();
        c_flat[15:0]    = 16'h8001;
        c_flat[255:240] = 16'h7FFE;
        push_exp(c_flat, 1'b0);
        tx_ready = 1'b1;
        @(posedge clk); #1 done2 = 1'b1;
        @(posedge clk); #1 done2 = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (frame_done2) break;
            if (tx_valid2 && tx_ready) got2.push_back(tx_data2);
        end
        n_cmp++; if (got2.size() !== 32) begin n_fail++; $display("FAIL nohdr_count: got %0d bytes want 32", got2.size()); end
        if (got2.size() == 32) begin
            n_cmp++; if (got2[0] !== 8'h80)  begin n_fail++; $display("FAIL nohdr_b0: got %h want 80", got2[0]); end
            n_cmp++; if (got2[1] !== 8'h01)  begin n_fail++; $display("FAIL nohdr_b1: got %h want 01", got2[1]); end
            n_cmp++; if (got2[30] !== 8'h7F) begin n_fail++; $display("FAIL nohdr_b30: got %h want 7f", got2[30]); end
            n_cmp++; if (got2[31] !== 8'hFE) begin n_fail++; $display("FAIL nohdr_b31: got %h want fe", got2[31]); end
        end
        while (got2.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got2.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL nohdr_byte: got %h want %h", g, e); end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, cyc2;
        clear_q();
        c_flat = kpat();
        push_exp(c_flat, 1'b1);
        tx_ready = 1'b1;
        pulse_done();
        wait_fd(cyc);
        n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_fd: got %b want 1", frame_done); end
        c_flat = bpat();
        push_exp(c_flat, 1'b1);
        done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_restart: got v=%b d=%h busy=%b want v=1 d=a5 busy=1", tx_valid, tx_data, busy);
        end
        wait_fd(cyc2);
        n_cmp++; if (cyc2 !== 33) begin n_fail++; $display("FAIL b2b_latency: got %0d edges want 33", cyc2); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
        n_cmp++; if (got.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL b2b_count: got %0d bytes want %0d", got.size(), exp_q.size());
        end
        while (got.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL b2b_byte: got %h want %h", g, e); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overrun();
        test_reset_mid();
        test_no_hdr();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/result_uart_drain.md
Name: result_uart_drain

Overview:
- Reader end of the 4x4 systolic array result interface.
- Captures all 16 signed 16-bit results (C0..C15) in the cycle the array asserts done. The array clears its PEs on the following edge, so capture must happen in that cycle.
- Serialises the captured frame as a byte stream to the UART transmitter over a valid/ready handshake.
- Sits between systolic_array and the UART TX in the FPGA top level.

Parameters:
- NUM_RES, 16, number of result words per frame (C0..C(NUM_RES-1)).
- RES_W, 16, result width; fixed at 16, each result is sent as 2 bytes.
- HDR_EN, 1, when 1, each frame is preceded by a header byte.
- HDR_BYTE, 8'hA5, value of the header byte.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- done  input  1  one-cycle pulse from the array; results valid while done=1.
- c_flat  input  NUM_RES*RES_W  packed results; C0 in bits [15:0], Ck in bits [16k+15:16k].
- tx_data  output  8  byte presented to the UART TX.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  UART TX accepts the byte this cycle.
- busy  output  1  frame captured and not yet fully sent.
- frame_done  output  1  one-cycle pulse after the last byte of a frame is accepted.
- overrun  output  1  sticky flag: done arrived while busy.

Behaviour:
- Reset (asynchronous, immediate):
  - Outputs: tx_data=0, tx_valid=0, busy=0, frame_done=0, overrun=0.
  - Internal state: state=IDLE, res_idx=0, byte_sel=0.
  - Shadow bank contents are don't-care.
  - An assertion mid-frame aborts the frame; no partial resumption after release.
- FSM states: IDLE, HDR, HI, LO.
  - IDLE: on a rising edge with done=1, latch all of c_flat into the shadow bank; res_idx<=0; busy<=1; tx_valid<=1.
    - HDR_EN=1: go to HDR with tx_data<=HDR_BYTE.
    - HDR_EN=0: go to HI with tx_data<=shadow C0[15:8], taken directly from c_flat.
  - HDR: on transfer, go to HI with tx_data<=C[res_idx][15:8].
  - HI: on transfer, go to LO with tx_data<=C[res_idx][7:0].
  - LO: on transfer:
    - res_idx < NUM_RES-1: res_idx++, go to HI with tx_data<=next result high byte.
    - res_idx == NUM_RES-1: tx_valid<=0, busy<=0, frame_done<=1 for one cycle, go to IDLE.
- Transfer rule: a transfer occurs on a rising edge where tx_valid=1 and tx_ready=1.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable.
  - tx_valid never drops without a transfer, except on reset.
- Byte order: header, C0 hi, C0 lo, C1 hi, ..., C15 lo.
  - With HDR_EN=1: 33 bytes per frame. With HDR_EN=0: 32 bytes.
- Latency: done sampled at edge k gives tx_valid=1 with the first byte after edge k.
  - With tx_ready held at 1, frame_done pulses after edge k+33 (HDR_EN=1).
- Back-to-back frames:
  - frame_done and IDLE are entered on the same edge.
  - done=1 in the cycle frame_done=1 is accepted as a new capture.
  - The minimum gap between accepted captures is 34 cycles (HDR_EN=1).
- Overrun: done=1 sampled while busy=1 (HDR/HI/LO) sets overrun<=1.
  - The shadow bank is not modified; the current frame continues unchanged.
  - overrun clears only on reset.
- Shadow bank: written only on an IDLE capture; stable for the whole frame even if c_flat changes.
- Results are passed through as raw bits; no sign handling is needed.

Decomposition:
- Shared package: FSM state encodings (IDLE, HDR, HI, LO; 2-bit); default HDR_BYTE; the BYTES_PER_RES=2 constant.
- No sub-module: the shadow bank, byte mux and FSM form one block.
- The byte select is a simple indexed part-select of the shadow bank by res_idx and byte_sel.

Test Plan:
- Reset, then drive c_flat with Ck=16'h0100*k+k and a one-cycle done, tx_ready=1.
  -> Bytes A5,00,00,01,01,02,02,...,0F,0F; frame_done one cycle after the 33rd transfer; busy low afterwards.
- Same frame with tx_ready toggling 1,0,0,1,...
  -> tx_data stable throughout every ready=0 stall; same 33-byte sequence; no byte dropped or duplicated.
- done pulse while busy, with c_flat changed to all 16'hFFFF.
  -> overrun=1 and stays 1; the in-flight frame still carries the original values.
- Assert reset during the 10th byte with tx_ready=0.
  -> tx_valid=0, busy=0, overrun=0 immediately, without waiting for a clock edge. Then a fresh done yields a complete frame starting with A5.
- HDR_EN=0, C0=16'h8001, C15=16'h7FFE.
  -> First byte 80, second 01; last two bytes 7F, FE; 32 bytes in total.
- done asserted in the same cycle as frame_done.
  -> Captured; the next frame starts on the following cycle; overrun stays 0.
